// File: rtl/data_mem_pkg.sv
// Shared types and LFSR constants for the data-memory responder and its arbiter.
package data_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_mem_responder_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr+1 (wrapping) and returns the first requester.
module rr_arbiter #(
  parameter int N    = 1,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (((int'(ptr) + i) % N) == j)) begin
          any       = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDXW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of mem_if: CHANNELS four-phase read/write ports share one array, one access at a time.
// Define DATA_MEM_RAND_LATENCY_EN to add 0-3 LFSR-chosen WAIT cycles to every access.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 1,
  parameter int LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [CHANNELS-1:0]           read_ready,
  output logic [CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [CHANNELS-1:0]           write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [CHANNELS*DATA_BITS-1:0] write_data,
  output logic [CHANNELS-1:0]           write_ready
);

  localparam int IDXW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW  = $clog2(LATENCY + 3) + 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t state, state_next;
  op_t    op;

  logic [IDXW-1:0]      cur, grant_ptr, grant_idx;
  logic [CHANNELS-1:0]  pending, grant;
  logic                 any_pending;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic [CNTW-1:0]      count, count_load;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 cur_valid, grant_read;
  logic [ADDR_BITS-1:0] grant_raddr, grant_waddr;
  logic [DATA_BITS-1:0] grant_wdata;
  logic                 latch, commit, release_ch;

  // A channel still holding ready is finishing its handshake and must not be re-granted.
  assign pending = (read_valid | write_valid) & ~(read_ready | write_ready);

  rr_arbiter #(.N(CHANNELS), .IDXW(IDXW)) u_arb (
    .req       (pending),
    .ptr       (grant_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_pending)
  );

`ifdef DATA_MEM_RAND_LATENCY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_step(lfsr);
  end

  assign count_load = CNTW'(LATENCY - 1) + CNTW'(lfsr[1:0]);
`else
  assign count_load = CNTW'(LATENCY - 1);
`endif

  always_comb begin
    grant_read  = 1'b0;
    grant_raddr = '0;
    grant_waddr = '0;
    grant_wdata = '0;
    cur_valid   = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant[j]) begin
        grant_read  = read_valid[j];
        grant_raddr = read_address[j*ADDR_BITS +: ADDR_BITS];
        grant_waddr = write_address[j*ADDR_BITS +: ADDR_BITS];
        grant_wdata = write_data[j*DATA_BITS +: DATA_BITS];
      end
      if (cur == IDXW'(j)) cur_valid = (op == OP_READ) ? read_valid[j] : write_valid[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Dropping the latched valid before commit aborts the access with no side effects.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    commit     = 1'b0;
    release_ch = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_pending) begin
          state_next = WAIT;
          latch      = 1'b1;
        end
      end
      WAIT: begin
        if (!cur_valid) begin
          state_next = IDLE;
        end else if (count == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        if (!cur_valid) begin
          state_next = IDLE;
          release_ch = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= '0;
      op          <= OP_READ;
      addr        <= '0;
      wdata       <= '0;
      count       <= '0;
      grant_ptr   <= '0;
      read_ready  <= '0;
      write_ready <= '0;
      read_data   <= '0;
    end else begin
      if (latch) begin
        cur   <= grant_idx;
        op    <= grant_read ? OP_READ : OP_WRITE;
        addr  <= grant_read ? grant_raddr : grant_waddr;
        wdata <= grant_wdata;
        count <= count_load;
      end else if (state == WAIT && count != '0) begin
        count <= count - CNTW'(1);
      end
      if (release_ch) grant_ptr <= cur;
      for (int j = 0; j < CHANNELS; j++) begin
        if (cur == IDXW'(j)) begin
          if (commit && op == OP_READ) begin
            read_ready[j]                        <= 1'b1;
            read_data[j*DATA_BITS +: DATA_BITS]  <= mem[addr];
          end
          if (commit && op == OP_WRITE) write_ready[j] <= 1'b1;
          if (release_ch) begin
            read_ready[j]  <= 1'b0;
            write_ready[j] <= 1'b0;
          end
        end
      end
    end
  end

  // Writes land on the commit edge, so any later grant already sees the new word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && op == OP_WRITE) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-built corner sequences, random batches vs a memory model.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int CH  = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2;
`ifdef DATA_MEM_RAND_LATENCY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif
  localparam int W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     read_valid, read_ready, write_valid, write_ready;
  logic [CH*AB-1:0]  read_address, write_address;
  logic [CH*DB-1:0]  read_data, write_data;

  data_mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read_valid    (read_valid),
    .read_address  (read_address),
    .read_ready    (read_ready),
    .read_data     (read_data),
    .write_valid   (write_valid),
    .write_address (write_address),
    .write_data    (write_data),
    .write_ready   (write_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [DB-1:0] model_mem [2**AB];
  logic [1:0]    ptr_model;
  logic [W-1:0]  exp_q[$];
  logic [1:0]    order_log[$];
  logic [DB-1:0] got [CH];
  logic [DB-1:0] last_rdata;

  typedef struct {
    logic          act;
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } req_t;
  req_t req [CH];

  typedef struct {
    logic [1:0]    ch;
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic [DB-1:0] exp_rdata;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AB; i++) model_mem[i] = '0;
    ptr_model = 2'd0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < CH; i++) req[i] = '{1'b0, 1'b0, 8'h00, 8'h00};
  endtask

  // Round-robin resumes after the last channel served; expected results follow that order.
  task automatic run_batch();
    logic [CH-1:0] pend, done_v, drop_v;
    logic [1:0]    c;
    logic [W-1:0]  e, act;
    int            remaining, cyc, since, svc, gap;
    pend = '0;
    for (int i = 0; i < CH; i++) pend[i] = req[i].act;
    exp_q.delete();
    order_log.delete();
    while (pend != '0) begin
      c = ptr_model;
      do c = c + 2'd1; while (!pend[c]);
      pend[c]   = 1'b0;
      ptr_model = c;
      if (req[c].wr) begin
        model_mem[req[c].addr] = req[c].data;
        exp_q.push_back({c, 1'b1, req[c].data});
      end else begin
        exp_q.push_back({c, 1'b0, model_mem[req[c].addr]});
      end
    end

    remaining = 0;
    for (int i = 0; i < CH; i++) begin
      if (req[i].act) begin
        remaining++;
        if (req[i].wr) begin
          write_address[i*AB +: AB] = req[i].addr;
          write_data[i*DB +: DB]    = req[i].data;
          write_valid[i]            = 1'b1;
        end else begin
          read_address[i*AB +: AB]  = req[i].addr;
          read_valid[i]             = 1'b1;
        end
      end
    end

    done_v = '0; drop_v = '0; cyc = 0; since = 0; svc = 0;
    while ((remaining > 0 || drop_v != '0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      since++;
      for (int i = 0; i < CH; i++) begin
        if (drop_v[i]) begin
          check(!read_ready[i] && !write_ready[i], "ready_drop", 32'({read_ready[i], write_ready[i]}), 32'd0);
          if (!req[i].wr) check(read_data[i*DB +: DB] == got[i], "data_hold", 32'(read_data[i*DB +: DB]), 32'(got[i]));
          drop_v[i] = 1'b0;
        end
      end
      check($countones(read_ready | write_ready) <= 1, "one_ready", 32'({read_ready, write_ready}), 32'd0);
      for (int i = 0; i < CH; i++) begin
        if ((read_ready[i] || write_ready[i]) && !done_v[i]) begin
          check(req[i].act && exp_q.size() > 0, "spurious_ready", 32'(i), 32'(exp_q.size()));
          if (req[i].act && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {2'(i), write_ready[i], write_ready[i] ? req[i].data : read_data[i*DB +: DB]};
            check(act == e, "service", 32'(act), 32'(e));
            gap = (svc == 0) ? LAT + 1 : LAT + 2;
            check(since >= gap && since <= gap + EXTRA, "latency", 32'(since), 32'(gap));
            got[i] = read_data[i*DB +: DB];
            if (!write_ready[i]) last_rdata = read_data[i*DB +: DB];
            order_log.push_back(2'(i));
            done_v[i] = 1'b1;
            drop_v[i] = 1'b1;
            read_valid[i]  = 1'b0;
            write_valid[i] = 1'b0;
            remaining--;
            svc++;
            since = 0;
          end
        end
      end
    end
    check(remaining == 0, "batch_done", 32'(remaining), 32'd0);
    read_valid  = '0;
    write_valid = '0;
  endtask

  task automatic wait_ready(input logic [1:0] ch, input logic wr, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(wr ? write_ready[ch] : read_ready[ch]) && cyc < 60);
    if (!(wr ? write_ready[ch] : read_ready[ch])) cyc = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           cyc, ops;
    logic         seen;
    logic [1:0]   exp_order [4];

    vecs[0] = '{2'd0, 1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{2'd0, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{2'd2, 1'b1, 8'hFF, 8'h77, 8'h00};
    vecs[3] = '{2'd1, 1'b0, 8'hFF, 8'h00, 8'h77};
    vecs[4] = '{2'd3, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{2'd1, 1'b1, 8'h00, 8'hC3, 8'h00};
    vecs[6] = '{2'd3, 1'b0, 8'h00, 8'h00, 8'hC3};
    exp_order = '{2'd1, 2'd2, 2'd3, 2'd0};

    reset = 1'b1;
    read_valid = '0; write_valid = '0;
    read_address = '0; write_address = '0; write_data = '0;
    last_rdata = '0;
    for (int i = 0; i < CH; i++) got[i] = '0;
    model_reset();
    clear_reqs();
    repeat (3) @(negedge clk);
    check(read_ready == '0, "reset_read_ready", 32'(read_ready), 32'd0);
    check(write_ready == '0, "reset_write_ready", 32'(write_ready), 32'd0);
    check(read_data == '0, "reset_read_data", read_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed single-channel vectors
    for (int v = 0; v < 7; v++) begin
      clear_reqs();
      req[vecs[v].ch] = '{1'b1, vecs[v].wr, vecs[v].addr, vecs[v].wdata};
      run_batch();
      if (!vecs[v].wr) check(last_rdata == vecs[v].exp_rdata, "vec_rdata", 32'(last_rdata), 32'(vecs[v].exp_rdata));
    end

    // Preload 0..3 from channel 0, then all four channels read at once
    for (int a = 0; a < 4; a++) begin
      clear_reqs();
      req[0] = '{1'b1, 1'b1, 8'(a), 8'hA0 + 8'(a)};
      run_batch();
    end
    clear_reqs();
    for (int i = 0; i < CH; i++) req[i] = '{1'b1, 1'b0, 8'(i), 8'h00};
    run_batch();
    for (int k = 0; k < 4; k++) begin
      check(k < order_log.size() && order_log[k] == exp_order[k], "rr_order",
            32'(k < order_log.size() ? order_log[k] : 2'd0), 32'(exp_order[k]));
      check(got[k] == 8'hA0 + 8'(k), "rr_data", 32'(got[k]), 32'(8'hA0 + 8'(k)));
    end

    // Serve channel 3 so channel 0 wins next; its write must be seen by channel 1's read
    clear_reqs();
    req[3] = '{1'b1, 1'b0, 8'h01, 8'h00};
    run_batch();
    clear_reqs();
    req[0] = '{1'b1, 1'b1, 8'h20, 8'h33};
    req[1] = '{1'b1, 1'b0, 8'h20, 8'h00};
    run_batch();
    check(order_log.size() > 0 && order_log[0] == 2'd0, "raw_first", 32'(order_log.size() > 0 ? order_log[0] : 2'd3), 32'd0);
    check(got[1] == 8'h33, "raw_data", 32'(got[1]), 32'h33);

    // Aborted read: valid dropped one cycle into WAIT
    read_address[7:0] = 8'h30;
    read_valid[0] = 1'b1;
    @(negedge clk);
    read_valid[0] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (read_ready != '0 || write_ready != '0) seen = 1'b1;
    end
    check(!seen, "abort_read_no_ready", 32'(seen), 32'd0);

    clear_reqs();
    req[1] = '{1'b1, 1'b1, 8'h30, 8'h11};
    run_batch();

    // Aborted write must leave the word untouched
    write_address[23:16] = 8'h30;
    write_data[23:16] = 8'hEE;
    write_valid[2] = 1'b1;
    @(negedge clk);
    write_valid[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (read_ready != '0 || write_ready != '0) seen = 1'b1;
    end
    check(!seen, "abort_write_no_ready", 32'(seen), 32'd0);
    clear_reqs();
    req[3] = '{1'b1, 1'b0, 8'h30, 8'h00};
    run_batch();
    check(last_rdata == 8'h11, "abort_write_kept", 32'(last_rdata), 32'h11);

    // One channel raising read and write together: read first, write after read drops
    read_address[23:16]  = 8'h30;
    write_address[23:16] = 8'h31;
    write_data[23:16]    = 8'h66;
    read_valid[2]  = 1'b1;
    write_valid[2] = 1'b1;
    wait_ready(2'd2, 1'b0, cyc);
    check(cyc > 0, "dual_read_ready", 32'(cyc), 32'd1);
    check(!write_ready[2], "dual_read_first", 32'(write_ready[2]), 32'd0);
    check(read_data[23:16] == 8'h11, "dual_read_data", 32'(read_data[23:16]), 32'h11);
    read_valid[2] = 1'b0;
    wait_ready(2'd2, 1'b1, cyc);
    check(cyc > 0, "dual_write_ready", 32'(cyc), 32'd1);
    write_valid[2] = 1'b0;
    @(negedge clk);
    check(write_ready == '0 && read_ready == '0, "dual_drop", 32'({read_ready, write_ready}), 32'd0);
    model_mem[8'h31] = 8'h66;
    ptr_model = 2'd2;
    clear_reqs();
    req[0] = '{1'b1, 1'b0, 8'h31, 8'h00};
    run_batch();
    check(last_rdata == 8'h66, "dual_write_landed", 32'(last_rdata), 32'h66);

    // Reset while a read response is being held
    read_address[7:0] = 8'h10;
    read_valid[0] = 1'b1;
    wait_ready(2'd0, 1'b0, cyc);
    check(cyc > 0 && read_data[7:0] == 8'h5A, "pre_reset_read", 32'(read_data[7:0]), 32'h5A);
    reset = 1'b1;
    read_valid = '0;
    #1;
    check(read_ready == '0, "mid_reset_ready", 32'(read_ready), 32'd0);
    check(read_data == '0, "mid_reset_data", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    clear_reqs();
    req[0] = '{1'b1, 1'b0, 8'h10, 8'h00};
    run_batch();
    check(last_rdata == 8'h00, "post_reset_read", 32'(last_rdata), 32'd0);

    // Random batches over a small address window to force collisions
    ops = 0;
    while (ops < 100) begin
      clear_reqs();
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          req[i].act  = 1'b1;
          req[i].wr   = 1'($urandom_range(0, 1));
          req[i].addr = 8'h40 + 8'($urandom_range(0, 7));
          req[i].data = 8'($urandom);
          ops++;
        end
      end
      run_batch();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
